// File: rtl/osd_video_pkg.sv
// osd_video_pkg
// Shared types and constants for the PAL on-screen-display video path.
// Holds the line-type and pixel-code encodings, the 5-bit DAC levels
// and the default line timing (16 MHz clock, 1024 cycles per 64 us line).
// No ports; imported by osd_pixel_fetch and osd_line_encoder.
package osd_video_pkg;

  typedef enum logic [1:0] {
    LT_NORMAL = 2'd0,
    LT_BLANK  = 2'd1,
    LT_EQ     = 2'd2,
    LT_BROAD  = 2'd3
  } line_type_e;

  typedef enum logic [1:0] {
    PX_BLACK       = 2'd0,
    PX_GREY        = 2'd1,
    PX_WHITE       = 2'd2,
    PX_TRANSPARENT = 2'd3
  } pixel_e;

  typedef enum logic [2:0] {
    ST_SYNC        = 3'd0,
    ST_BACK_PORCH  = 3'd1,
    ST_ACTIVE      = 3'd2,
    ST_FRONT_PORCH = 3'd3,
    ST_HALF_PULSE  = 3'd4,
    ST_HALF_HIGH   = 3'd5
  } seg_state_e;

  localparam logic [4:0] LEVEL_SYNC  = 5'd0;
  localparam logic [4:0] LEVEL_BLACK = 5'd9;
  localparam logic [4:0] LEVEL_GREY  = 5'd20;
  localparam logic [4:0] LEVEL_WHITE = 5'd31;

  localparam int DEF_LINE_CYCLES   = 1024;
  localparam int DEF_HSYNC_CYCLES  = 75;
  localparam int DEF_BP_CYCLES     = 91;
  localparam int DEF_ACTIVE_CYCLES = 832;
  localparam int DEF_EQ_CYCLES     = 38;
  localparam int DEF_BROAD_CYCLES  = 437;
  localparam int DEF_PIXEL_DIV     = 4;

  // Transparent pixels have nothing underneath them in this design, so
  // they fall through to black together with the explicit black code.
  function automatic logic [4:0] pixel_level(input pixel_e px);
    case (px)
      PX_GREY:  return LEVEL_GREY;
      PX_WHITE: return LEVEL_WHITE;
      default:  return LEVEL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/osd_pixel_fetch.sv
// osd_pixel_fetch
// Pixel-slot divider and handshake for the active part of a NORMAL line.
// Raises pixReady one cycle before each PIXEL_DIV-wide pixel slot, latches
// the offered pixel (or black when nothing was offered) and flags a missed
// slot with a one-cycle underrun pulse.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-low reset
//   fetchEn_i    in   line is running and of type NORMAL
//   pos_i        in   current position within the line
//   pixData_i    in   2-bit pixel code from the pixel source
//   pixValid_i   in   pixData_i is valid
//   pixReady_o   out  pixel is sampled at the end of this cycle
//   underrun_o   out  previous slot had no valid pixel
//   pixel_o      out  pixel driving the current slot
module osd_pixel_fetch
  import osd_video_pkg::*;
#(
  parameter int LINE_CYCLES   = DEF_LINE_CYCLES,
  parameter int ACTIVE_START  = DEF_HSYNC_CYCLES + DEF_BP_CYCLES,
  parameter int ACTIVE_CYCLES = DEF_ACTIVE_CYCLES,
  parameter int PIXEL_DIV     = DEF_PIXEL_DIV,
  localparam int POS_W        = $clog2(LINE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetchEn_i,
  input  logic [POS_W-1:0] pos_i,
  input  logic [1:0]       pixData_i,
  input  logic             pixValid_i,
  output logic             pixReady_o,
  output logic             underrun_o,
  output pixel_e           pixel_o
);

  // pixReady is registered, so it is armed two positions ahead of the
  // slot: armed at pos, visible at pos+1, pixel latched for pos+2 onward.
  localparam logic [POS_W-1:0] ARM_FIRST = POS_W'(ACTIVE_START - 2);
  localparam logic [POS_W-1:0] ARM_LAST  = POS_W'(ACTIVE_START - 2 + ACTIVE_CYCLES - PIXEL_DIV);
  localparam logic [POS_W-1:0] DIV_W     = POS_W'(PIXEL_DIV);

  logic [POS_W-1:0] armOffset;
  logic             pixReady_d;
  logic             pixReady_q;
  logic             underrun_q;
  pixel_e           pixel_q;

  // Decide whether the next position is a pixel-request position.
  always_comb begin
    armOffset  = pos_i - ARM_FIRST;
    pixReady_d = fetchEn_i && (pos_i >= ARM_FIRST) && (pos_i <= ARM_LAST)
                 && ((armOffset % DIV_W) == '0);
  end

  // Handshake register: a missed slot shows black and pulses underrun once;
  // there is no retry, so the following slot requests as normal.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pixReady_q <= 1'b0;
      underrun_q <= 1'b0;
      pixel_q    <= PX_BLACK;
    end else begin
      pixReady_q <= pixReady_d;
      underrun_q <= pixReady_q && !pixValid_i;
      if (pixReady_q) begin
        pixel_q <= pixValid_i ? pixel_e'(pixData_i) : PX_BLACK;
      end
    end
  end

  assign pixReady_o = pixReady_q;
  assign underrun_o = underrun_q;
  assign pixel_o    = pixel_q;

endmodule

// File: rtl/osd_line_encoder.sv
// osd_line_encoder
// Per-cycle PAL line encoder: turns the line type from the frame tracker and
// 2-bit OSD pixels into a 5-bit code for the resistor-ladder DAC.
// Ports:
//   clk          in   16 MHz clock
//   rst          in   synchronous active-low reset
//   line_type    in   NORMAL/BLANK/EQ/BROAD, sampled while line_start is high
//   line_start   out  one-cycle pulse at position 0 of every line
//   pix_data     in   pixel code: black, grey, white, transparent
//   pix_valid    in   pix_data is valid
//   pix_ready    out  pix_data is sampled at the end of this cycle
//   underrun     out  one-cycle pulse after a pixel slot was missed
//   video_level  out  registered DAC code, one cycle behind the position
module osd_line_encoder
  import osd_video_pkg::*;
#(
  parameter int LINE_CYCLES   = DEF_LINE_CYCLES,
  parameter int HSYNC_CYCLES  = DEF_HSYNC_CYCLES,
  parameter int BP_CYCLES     = DEF_BP_CYCLES,
  parameter int ACTIVE_CYCLES = DEF_ACTIVE_CYCLES,
  parameter int EQ_CYCLES     = DEF_EQ_CYCLES,
  parameter int BROAD_CYCLES  = DEF_BROAD_CYCLES,
  parameter int PIXEL_DIV     = DEF_PIXEL_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] line_type,
  output logic       line_start,
  input  logic [1:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic       underrun,
  output logic [4:0] video_level
);

  localparam int POS_W        = $clog2(LINE_CYCLES);
  localparam int ACTIVE_START = HSYNC_CYCLES + BP_CYCLES;

  localparam logic [POS_W-1:0] POS_LAST     = POS_W'(LINE_CYCLES - 1);
  localparam logic [POS_W-1:0] POS_HALF     = POS_W'(LINE_CYCLES / 2);
  localparam logic [POS_W-1:0] POS_BP       = POS_W'(HSYNC_CYCLES);
  localparam logic [POS_W-1:0] POS_ACTIVE   = POS_W'(ACTIVE_START);
  localparam logic [POS_W-1:0] POS_FP       = POS_W'(ACTIVE_START + ACTIVE_CYCLES);
  localparam logic [POS_W-1:0] EQ_WIDTH     = POS_W'(EQ_CYCLES);
  localparam logic [POS_W-1:0] BROAD_WIDTH  = POS_W'(BROAD_CYCLES);

  logic             run_q;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  line_type_e       curType_q;
  line_type_e       lineTypeIn;
  seg_state_e       state_q;
  seg_state_e       state_d;
  logic [4:0]       videoLevel_q;
  logic [4:0]       level_d;
  logic [POS_W-1:0] pulseWidth;
  logic             fetchEn;
  pixel_e           pixel;

  assign lineTypeIn = line_type_e'(line_type);

  // run_q holds the counter at 0 for the first cycle after reset release,
  // so that cycle is position 0 and carries the line_start pulse.
  assign line_start = run_q && (pos_q == '0);
  assign fetchEn    = run_q && (curType_q == LT_NORMAL);

  osd_pixel_fetch #(
    .LINE_CYCLES  (LINE_CYCLES),
    .ACTIVE_START (ACTIVE_START),
    .ACTIVE_CYCLES(ACTIVE_CYCLES),
    .PIXEL_DIV    (PIXEL_DIV)
  ) u_fetch (
    .clk       (clk),
    .rst       (rst),
    .fetchEn_i (fetchEn),
    .pos_i     (pos_q),
    .pixData_i (pix_data),
    .pixValid_i(pix_valid),
    .pixReady_o(pix_ready),
    .underrun_o(underrun),
    .pixel_o   (pixel)
  );

  // Segment state for the current position. Position 0 always restarts the
  // line from the freshly sampled line_type; elsewhere the latched type
  // decides the half-line pulse width.
  always_comb begin
    pos_d      = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
    pulseWidth = (curType_q == LT_BROAD) ? BROAD_WIDTH : EQ_WIDTH;
    state_d    = state_q;
    if (pos_q == '0) begin
      state_d = ((lineTypeIn == LT_EQ) || (lineTypeIn == LT_BROAD)) ? ST_HALF_PULSE : ST_SYNC;
    end else begin
      case (state_q)
        ST_SYNC:        if (pos_q == POS_BP)     state_d = ST_BACK_PORCH;
        ST_BACK_PORCH:  if (pos_q == POS_ACTIVE) state_d = ST_ACTIVE;
        ST_ACTIVE:      if (pos_q == POS_FP)     state_d = ST_FRONT_PORCH;
        ST_FRONT_PORCH: state_d = ST_FRONT_PORCH;
        ST_HALF_PULSE:  if ((pos_q == pulseWidth) || (pos_q == POS_HALF + pulseWidth))
                          state_d = ST_HALF_HIGH;
        ST_HALF_HIGH:   if (pos_q == POS_HALF)   state_d = ST_HALF_PULSE;
        default:        state_d = ST_SYNC;
      endcase
    end
  end

  // DAC level for the current position; BLANK lines keep the active
  // window at black and never request pixels.
  always_comb begin
    level_d = LEVEL_BLACK;
    case (state_d)
      ST_SYNC, ST_HALF_PULSE: level_d = LEVEL_SYNC;
      ST_ACTIVE:              level_d = (curType_q == LT_NORMAL) ? pixel_level(pixel) : LEVEL_BLACK;
      default:                level_d = LEVEL_BLACK;
    endcase
  end

  // Position counter, line-type latch, segment FSM and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q        <= 1'b0;
      pos_q        <= '0;
      curType_q    <= LT_NORMAL;
      state_q      <= ST_SYNC;
      videoLevel_q <= LEVEL_BLACK;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        pos_q        <= pos_d;
        state_q      <= state_d;
        videoLevel_q <= level_d;
        if (pos_q == '0) begin
          curType_q <= lineTypeIn;
        end
      end
    end
  end

  assign video_level = videoLevel_q;

endmodule

// File: tb/tb_osd_line_encoder.sv
// tb_osd_line_encoder
// Directed bench for osd_line_encoder: whole lines are played from a table
// of line vectors and their recorded levels, pixel requests and underruns
// are compared against hand-written level spans and request positions.
module tb_osd_line_encoder;
  import osd_video_pkg::*;

  typedef struct {
    int         len;
    logic [4:0] lvl;
  } span_t;

  typedef struct {
    string      name;
    logic [1:0] lt;
    logic [1:0] px;
    int         drop;
    int         spanFirst;
    int         spanCount;
    int         expReady;
    int         expUnder;
  } line_vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] line_type = 2'd0;
  logic [1:0] pix_data = 2'd0;
  logic       pix_valid = 1'b0;
  logic       line_start;
  logic       pix_ready;
  logic       underrun;
  logic [4:0] video_level;

  int total = 0;
  int bad   = 0;

  logic [4:0] lvlRec   [1024];
  logic       readyRec [1024];
  logic       underRec [1024];

  span_t     spans [32];
  line_vec_t vecs  [7];

  osd_line_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .line_type  (line_type),
    .line_start (line_start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .underrun   (underrun),
    .video_level(video_level)
  );

  // 16 MHz nominal; the period only matters relative to the edges.
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Plays one line starting at the negedge of its position 0 (line_type
  // already set by the caller) and ends at the negedge of the next line's
  // position 0 with line_type set to nextLt. Levels are recorded one cycle
  // late because the DAC code is registered.
  task automatic applyStimulus(input logic [1:0] px, input int drop, input bit seqMode,
                               input logic [1:0] nextLt);
    int slot;
    for (int p = 0; p <= 1024; p++) begin
      if (p > 0) begin
        @(negedge clk);
        lvlRec[p-1] = video_level;
      end
      if (p == 1024) begin
        checkOutput("line_start at next line", {31'd0, line_start}, 32'd1);
        line_type = nextLt;
        pix_valid = 1'b1;
        pix_data  = 2'd2;
      end else begin
        readyRec[p] = pix_ready;
        underRec[p] = underrun;
        if (pix_ready === 1'b1) begin
          slot      = (p >= 165) ? (p - 165) / 4 : -1;
          pix_valid = (slot != drop);
          pix_data  = (slot == drop) ? 2'd2 : (seqMode ? 2'(slot % 4) : px);
        end else begin
          pix_valid = 1'b1;
          pix_data  = 2'd2;
        end
      end
    end
  endtask

  // Compares the recorded line with one table vector.
  task automatic checkLine(input line_vec_t v);
    int base;
    int errs;
    int firstBad;
    int readyCnt;
    int readyWrong;
    int firstReady;
    int underCnt;
    bit expR;
    base = 0;
    for (int s = 0; s < v.spanCount; s++) begin
      errs     = 0;
      firstBad = -1;
      for (int j = 0; j < spans[v.spanFirst+s].len; j++) begin
        if (lvlRec[base+j] !== spans[v.spanFirst+s].lvl) begin
          errs++;
          if (firstBad < 0) firstBad = base + j;
        end
      end
      checkOutput($sformatf("%s span%0d level %0d wrong-cycles (first pos %0d)",
                            v.name, s, spans[v.spanFirst+s].lvl, firstBad), errs, 0);
      base += spans[v.spanFirst+s].len;
    end
    readyCnt   = 0;
    readyWrong = 0;
    firstReady = -1;
    underCnt   = 0;
    for (int p = 0; p < 1024; p++) begin
      expR = (v.lt == LT_NORMAL) && (p >= 165) && (p <= 993) && (((p - 165) % 4) == 0);
      if (readyRec[p] === 1'b1) begin
        readyCnt++;
        if (firstReady < 0) firstReady = p;
      end
      if (readyRec[p] !== expR) readyWrong++;
      if (underRec[p] === 1'b1) underCnt++;
    end
    checkOutput({v.name, " pix_ready count"}, readyCnt, v.expReady);
    checkOutput({v.name, " pix_ready misplaced"}, readyWrong, 0);
    if (v.expReady > 0) checkOutput({v.name, " first pix_ready pos"}, firstReady, 165);
    checkOutput({v.name, " underrun count"}, underCnt, v.expUnder);
    if (v.drop >= 0) checkOutput({v.name, " underrun pos"}, {31'd0, underRec[166 + 4*v.drop]}, 32'd1);
  endtask

  initial begin
    logic [4:0] seqLvl [4];
    int errs;

    spans[0]  = '{75, 5'd0};   spans[1]  = '{91, 5'd9};   spans[2]  = '{832, 5'd31}; spans[3]  = '{26, 5'd9};
    spans[4]  = '{75, 5'd0};   spans[5]  = '{91, 5'd9};   spans[6]  = '{40, 5'd20};  spans[7]  = '{4, 5'd9};
    spans[8]  = '{788, 5'd20}; spans[9]  = '{26, 5'd9};
    spans[10] = '{38, 5'd0};   spans[11] = '{474, 5'd9};  spans[12] = '{38, 5'd0};   spans[13] = '{474, 5'd9};
    spans[14] = '{437, 5'd0};  spans[15] = '{75, 5'd9};   spans[16] = '{437, 5'd0};  spans[17] = '{75, 5'd9};
    spans[18] = '{75, 5'd0};   spans[19] = '{949, 5'd9};

    vecs[0] = '{"normal_white",  LT_NORMAL, 2'd2, -1, 0,  4, 208, 0};
    vecs[1] = '{"normal_drop10", LT_NORMAL, 2'd1, 10, 4,  6, 208, 1};
    vecs[2] = '{"eq_line",       LT_EQ,     2'd2, -1, 10, 4, 0,   0};
    vecs[3] = '{"broad_line",    LT_BROAD,  2'd2, -1, 14, 4, 0,   0};
    vecs[4] = '{"after_broad",   LT_NORMAL, 2'd2, -1, 0,  4, 208, 0};
    vecs[5] = '{"blank_line",    LT_BLANK,  2'd2, -1, 18, 2, 0,   0};
    vecs[6] = '{"transparent",   LT_NORMAL, 2'd3, -1, 18, 2, 208, 0};

    seqLvl[0] = 5'd9; seqLvl[1] = 5'd20; seqLvl[2] = 5'd31; seqLvl[3] = 5'd9;

    rst       = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 2'd2;
    repeat (3) @(negedge clk);
    checkOutput("reset video_level", video_level, 9);
    checkOutput("reset line_start", {31'd0, line_start}, 0);
    checkOutput("reset pix_ready", {31'd0, pix_ready}, 0);
    checkOutput("reset underrun", {31'd0, underrun}, 0);

    rst = 1'b1;
    @(negedge clk);
    checkOutput("line_start after release", {31'd0, line_start}, 1);
    checkOutput("level after release", video_level, 9);
    line_type = vecs[0].lt;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].px, vecs[i].drop, 1'b0, (i < 6) ? vecs[i+1].lt : LT_NORMAL);
      checkLine(vecs[i]);
    end

    applyStimulus(2'd0, -1, 1'b1, LT_NORMAL);
    for (int k = 0; k < 8; k++) begin
      errs = 0;
      for (int j = 0; j < 4; j++) begin
        if (lvlRec[166 + 4*k + j] !== seqLvl[k % 4]) errs++;
      end
      checkOutput($sformatf("sequence slot%0d wrong-cycles", k), errs, 0);
    end

    repeat (500) @(negedge clk);
    checkOutput("level before mid-line reset", video_level, 31);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset video_level", video_level, 9);
    checkOutput("mid reset pix_ready", {31'd0, pix_ready}, 0);
    checkOutput("mid reset underrun", {31'd0, underrun}, 0);
    checkOutput("mid reset line_start", {31'd0, line_start}, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("line_start after mid reset", {31'd0, line_start}, 1);
    line_type = LT_NORMAL;
    applyStimulus(2'd2, -1, 1'b0, LT_NORMAL);
    checkLine(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
